kernel_conv_sched: RTL

Sequencer for the Gaussian smoothing stage. Accepts one configuration (sigma, kernel size, image dimensions), starts the kernel generator and waits for it to finish. It then issues every valid convolution window centre to the downstream window/MAC engine over a valid/ready handshake. It reports a done pulse or a coded error, and supports abort at any point.

---
 rtl/kernel_conv_sched_pkg.sv | 24 ++
 rtl/kernel_conv_sched_if.sv | 34 +++
 rtl/kernel_conv_sched_window_scan_counter.sv | 39 +++
 rtl/kernel_conv_sched.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/kernel_conv_sched_pkg.sv
// Shared types for the Gaussian smoothing sequencer: FSM states,
// error codes and the window-centre coordinate width.
package kernel_sched_pkg;

    localparam int SCHED_MAX_DIM = 640;
    localparam int COORD_W = $clog2(SCHED_MAX_DIM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUILD,
        S_WAIT,
        S_SCAN,
        S_FINISH,
        S_FAIL
    } sched_state_t;

    typedef enum logic [1:0] {
        E_NONE    = 2'd0,
        E_CFG     = 2'd1,
        E_GEN     = 2'd2,
        E_TIMEOUT = 2'd3
    } sched_err_t;

endpackage

// File: rtl/kernel_conv_sched_if.sv
// Configuration and window-centre handshakes between the sequencer,
// its configuring host and the downstream window/MAC engine.
interface kernel_conv_sched_if #(
    parameter int MAX_KERNAL = 3,
    parameter int MAX_DIM    = 640
);
    localparam int KW = $clog2(MAX_KERNAL) + 1;
    localparam int DW = $clog2(MAX_DIM) + 1;
    localparam int CW = $clog2(MAX_DIM);

    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_sigma;
    logic [KW-1:0] cfg_ksize;
    logic [DW-1:0] cfg_width;
    logic [DW-1:0] cfg_height;
    logic          win_valid;
    logic          win_ready;
    logic [CW-1:0] win_x;
    logic [CW-1:0] win_y;

    modport master (
        output cfg_valid, cfg_sigma, cfg_ksize, cfg_width, cfg_height,
        output win_ready,
        input  cfg_ready, win_valid, win_x, win_y
    );

    modport slave (
        input  cfg_valid, cfg_sigma, cfg_ksize, cfg_width, cfg_height,
        input  win_ready,
        output cfg_ready, win_valid, win_x, win_y
    );

endinterface

// File: rtl/kernel_conv_sched_window_scan_counter.sv
// Raster stepping of window centres from (r,r) to (x_lim,y_lim);
// shared with the filter pipeline.
module window_scan_counter
    import kernel_sched_pkg::*;
#(
    parameter int CW = COORD_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [CW-1:0] r,
    input  logic [CW-1:0] x_lim,
    input  logic [CW-1:0] y_lim,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= r;
            y <= r;
        end else if (step) begin
            if (x < x_lim) begin
                x <= x + CW'(1);
            end else begin
                x <= r;
                y <= y + CW'(1);
            end
        end
    end

    assign last = (x == x_lim) && (y == y_lim);

endmodule

// File: rtl/kernel_conv_sched.sv
// Gaussian smoothing sequencer: validate config, run the kernel
// generator, then stream every valid window centre downstream.
module kernel_conv_sched
    import kernel_sched_pkg::*;
#(
    parameter int MAX_KERNAL = 3,
    parameter int MAX_DIM    = SCHED_MAX_DIM,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    kernel_conv_sched_if.slave            bus,
    input  logic                          abort,
    output logic                          kern_start,
    output logic [2:0]                    kern_sigma,
    output logic [$clog2(MAX_KERNAL):0]   kern_size,
    input  logic                          kern_done,
    input  logic                          kern_err,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    err_code
);

    localparam int KW = $clog2(MAX_KERNAL) + 1;
    localparam int DW = $clog2(MAX_DIM) + 1;
    localparam int CW = $clog2(MAX_DIM);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sched_state_t  state;
    sched_err_t    code_q;
    logic          rdy_q;
    logic          valid_q;
    logic [2:0]    sigma_q;
    logic [KW-1:0] ksize_q;
    logic [CW-1:0] r_q;
    logic [CW-1:0] xlim_q;
    logic [CW-1:0] ylim_q;
    logic [TW-1:0] cnt;

    logic [KW-1:0] r_in;
    logic [DW-1:0] ks_ext;
    logic          cfg_ok;
    logic          accept;
    logic          load;
    logic          step;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          last;

    assign r_in   = (bus.cfg_ksize - KW'(1)) >> 1;
    assign ks_ext = DW'(bus.cfg_ksize);
    assign cfg_ok = bus.cfg_ksize[0]
                 && (bus.cfg_ksize <= KW'(MAX_KERNAL))
                 && (ks_ext <= bus.cfg_width)
                 && (ks_ext <= bus.cfg_height);

    assign accept = bus.cfg_valid && rdy_q && (state == S_IDLE);
    // Error beats done when the generator raises both at once.
    assign load = !abort && (state == S_WAIT) && kern_done && !kern_err;
    assign step = !abort && (state == S_SCAN) && valid_q && bus.win_ready;

    window_scan_counter #(.CW(CW)) u_scan (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .r     (r_q),
        .x_lim (xlim_q),
        .y_lim (ylim_q),
        .x     (x),
        .y     (y),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            code_q     <= E_NONE;
            rdy_q      <= 1'b0;
            valid_q    <= 1'b0;
            kern_start <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            sigma_q    <= '0;
            ksize_q    <= '0;
            r_q        <= '0;
            xlim_q     <= '0;
            ylim_q     <= '0;
            cnt        <= '0;
        end else begin
            kern_start <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            if (abort && state != S_IDLE) begin
                state   <= S_IDLE;
                rdy_q   <= 1'b1;
                valid_q <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (accept) begin
                            rdy_q   <= 1'b0;
                            sigma_q <= bus.cfg_sigma;
                            ksize_q <= bus.cfg_ksize;
                            r_q     <= CW'(r_in);
                            xlim_q  <= CW'(bus.cfg_width - DW'(1) - DW'(r_in));
                            ylim_q  <= CW'(bus.cfg_height - DW'(1) - DW'(r_in));
                            if (cfg_ok) begin
                                code_q     <= E_NONE;
                                kern_start <= 1'b1;
                                state      <= S_BUILD;
                            end else begin
                                code_q <= E_CFG;
                                err    <= 1'b1;
                                state  <= S_FAIL;
                            end
                        end else begin
                            rdy_q <= 1'b1;
                        end
                    end
                    S_BUILD: begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        cnt <= cnt + TW'(1);
                        if (kern_err) begin
                            code_q <= E_GEN;
                            err    <= 1'b1;
                            state  <= S_FAIL;
                        end else if (kern_done) begin
                            valid_q <= 1'b1;
                            state   <= S_SCAN;
                        end else if (cnt == TW'(TIMEOUT - 1)) begin
                            code_q <= E_TIMEOUT;
                            err    <= 1'b1;
                            state  <= S_FAIL;
                        end
                    end
                    S_SCAN: begin
                        if (bus.win_ready && last) begin
                            valid_q <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_FINISH;
                        end
                    end
                    S_FINISH, S_FAIL: begin
                        rdy_q <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: begin
                        rdy_q   <= 1'b1;
                        valid_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.cfg_ready = rdy_q;
    assign bus.win_valid = valid_q;
    assign bus.win_x     = x;
    assign bus.win_y     = y;
    assign kern_sigma    = sigma_q;
    assign kern_size     = ksize_q;
    assign err_code      = code_q;
    assign busy          = (state != S_IDLE);

endmodule
